// File: rtl/evict_write_buffer.sv
// rtl/evict_write_buffer.sv - line-granular write-back buffer between cache and main memory
//
// Accepts dirty-line evictions without waiting on memory, drains them to memory
// in FIFO order while the memory port is idle, serves reads that hit a buffered
// line and merges repeat writes to a buffered line in place.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   cache_read/write   line requests from the cache, held until cache_resp
//   cache_address      line address (bits [3:0] ignored)
//   cache_wdata        eviction data
//   cache_resp         one-cycle completion pulse to the cache
//   cache_rdata        read data, valid with cache_resp
//   pmem_read/write    memory strobes (decoded from state)
//   pmem_address       memory line address, bits [3:0] = 0
//   pmem_wdata         memory write data (head entry)
//   pmem_resp          memory completion
//   pmem_rdata         memory read data
//   count              number of valid buffered lines
//
// Optional build macro EVICT_BUF_STATS_EN adds stats_reset, fwd_count and
// coalesce_count.

module evict_write_buffer #(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cache_read,
    input  logic                       cache_write,
    input  logic [ADDR_W-1:0]          cache_address,
    input  logic [LINE_W-1:0]          cache_wdata,
    output logic                       cache_resp,
    output logic [LINE_W-1:0]          cache_rdata,
    output logic                       pmem_read,
    output logic                       pmem_write,
    output logic [ADDR_W-1:0]          pmem_address,
    output logic [LINE_W-1:0]          pmem_wdata,
    input  logic                       pmem_resp,
    input  logic [LINE_W-1:0]          pmem_rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef EVICT_BUF_STATS_EN
    ,
    input  logic                       stats_reset,
    output logic [15:0]                fwd_count,
    output logic [15:0]                coalesce_count
`endif
);

    localparam int TAG_W = ADDR_W - 4;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t              state;
    logic                valid_q [DEPTH];
    logic [TAG_W-1:0]    tag_q   [DEPTH];
    logic [LINE_W-1:0]   data_q  [DEPTH];
    logic [IDX_W-1:0]    head;
    logic [IDX_W-1:0]    tail;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [TAG_W-1:0]    req_tag;

    // Line offset bits are don't-care for a line-granular buffer.
    logic                unused_offset_bits;
    assign unused_offset_bits = ^cache_address[3:0];

    assign req_tag = cache_address[ADDR_W-1:4];

    // Coalescing keeps tags unique among valid entries, so at most one hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = i[IDX_W-1:0];
            end
        end
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_SLOT) ? '0 : idx + 1'b1;
    endfunction

    // Memory-side outputs depend only on state, so read and write strobes are
    // mutually exclusive by construction.
    assign cache_resp   = (state == S_RESP);
    assign pmem_read    = (state == S_READ);
    assign pmem_write   = (state == S_DRAIN);
    assign pmem_wdata   = data_q[head];
    assign pmem_address = (state == S_DRAIN) ? {tag_q[head], 4'b0000}
                                             : {req_tag, 4'b0000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            cache_rdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cache_read) begin
                        if (hit) begin
                            cache_rdata <= data_q[hit_idx];
                            state       <= S_RESP;
                        end else begin
                            state <= S_READ;
                        end
                    end else if (cache_write) begin
                        if (hit) begin
                            data_q[hit_idx] <= cache_wdata;
                            state           <= S_RESP;
                        end else if (count != FULL) begin
                            valid_q[tail] <= 1'b1;
                            tag_q[tail]   <= req_tag;
                            data_q[tail]  <= cache_wdata;
                            tail          <= next_idx(tail);
                            count         <= count + 1'b1;
                            state         <= S_RESP;
                        end else begin
                            // Full: free the head slot, then retry the write from IDLE.
                            state <= S_DRAIN;
                        end
                    end else if (count != '0) begin
                        state <= S_DRAIN;
                    end
                end
                S_READ: begin
                    if (pmem_resp) begin
                        cache_rdata <= pmem_rdata;
                        state       <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (pmem_resp) begin
                        valid_q[head] <= 1'b0;
                        head          <= next_idx(head);
                        count         <= count - 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef EVICT_BUF_STATS_EN
    logic fwd_inc;
    logic coalesce_inc;

    assign fwd_inc      = (state == S_IDLE) && cache_read && hit;
    assign coalesce_inc = (state == S_IDLE) && !cache_read && cache_write && hit;

    always_ff @(posedge clk) begin
        if (reset || stats_reset) begin
            fwd_count      <= '0;
            coalesce_count <= '0;
        end else begin
            if (fwd_inc && (fwd_count != 16'hFFFF)) begin
                fwd_count <= fwd_count + 16'd1;
            end
            if (coalesce_inc && (coalesce_count != 16'hFFFF)) begin
                coalesce_count <= coalesce_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_evict_write_buffer.sv
// tb/tb_evict_write_buffer.sv - directed self-checking bench for evict_write_buffer

module tb_evict_write_buffer;

    localparam int DEPTH   = 2;
    localparam int LINE_W  = 128;
    localparam int ADDR_W  = 16;
    localparam int MEM_LAT = 2;

    logic              clk;
    logic              reset;
    logic              cache_read;
    logic              cache_write;
    logic [ADDR_W-1:0] cache_address;
    logic [LINE_W-1:0] cache_wdata;
    logic              cache_resp;
    logic [LINE_W-1:0] cache_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;
    logic [1:0]        count;
`ifdef EVICT_BUF_STATS_EN
    logic              stats_reset;
    logic [15:0]       fwd_count;
    logic [15:0]       coalesce_count;
`endif

    evict_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_address (cache_address),
        .cache_wdata   (cache_wdata),
        .cache_resp    (cache_resp),
        .cache_rdata   (cache_rdata),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata),
        .count         (count)
`ifdef EVICT_BUF_STATS_EN
        ,
        .stats_reset   (stats_reset),
        .fwd_count     (fwd_count),
        .coalesce_count(coalesce_count)
`endif
    );

    localparam logic [LINE_W-1:0] DATA_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [LINE_W-1:0] DATA_B = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [LINE_W-1:0] DATA_C = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
    localparam logic [LINE_W-1:0] DATA_D1 = 128'hD1D1_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [LINE_W-1:0] DATA_D2 = 128'hD2D2_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [LINE_W-1:0] DATA_D3 = 128'hD3D3_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [LINE_W-1:0] DATA_E = 128'hEEEE_EEEE_EEEE_EEEE_0000_0000_0000_0000;
    // Memory model returns {8{addr ^ 16'hA5A5}}; for 0x4000 that is 16'hE5A5.
    localparam logic [LINE_W-1:0] RD_4000 = 128'hE5A5_E5A5_E5A5_E5A5_E5A5_E5A5_E5A5_E5A5;

    int vectors;
    int miscompares;
    int cyc;
    int wr_cycles;
    int rd_cycles;
    int both_cycles;
    int rd_resp_cyc;
    int wait_cnt;
    int lat;
    int resp_cyc;
    bit ok;
    bit mem_en;
    logic [LINE_W-1:0] got_rdata;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [LINE_W-1:0] wq_data[$];
    logic [ADDR_W-1:0] rq_addr[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: pulses pmem_resp MEM_LAT cycles into each access.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_write) wr_cycles++;
            if (pmem_read) rd_cycles++;
            if (pmem_write && pmem_read) both_cycles++;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                wait_cnt  = 0;
            end else if (mem_en && !reset && (pmem_read || pmem_write)) begin
                if (wait_cnt == MEM_LAT - 1) begin
                    wait_cnt = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        wq_addr.push_back(pmem_address);
                        wq_data.push_back(pmem_wdata);
                    end else begin
                        rq_addr.push_back(pmem_address);
                        pmem_rdata = {8{pmem_address ^ 16'hA5A5}};
                        rd_resp_cyc = cyc;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Presents one request and holds it until cache_resp (bounded).
    task automatic do_req(input bit rd, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] wd);
        cache_read    = rd;
        cache_write   = !rd;
        cache_address = addr;
        cache_wdata   = wd;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cache_resp) begin
                ok = 1'b1;
                break;
            end
        end
        got_rdata   = cache_rdata;
        resp_cyc    = cyc;
        cache_read  = 1'b0;
        cache_write = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL req_timeout addr=%h: no cache_resp within 60 cycles", addr);
        end
    endtask

    task automatic wait_empty();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (count == 0 && !pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_timeout count=%0d required 0", count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({cache_resp, pmem_read, pmem_write} !== 3'b000 || count !== 2'd0 || cache_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_state resp/rd/wr=%b count=%0d rdata=%h required 000/0/0",
                     {cache_resp, pmem_read, pmem_write}, count, cache_rdata);
        end
`ifdef EVICT_BUF_STATS_EN
        vectors++;
        if (fwd_count !== 16'd0 || coalesce_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_stats fwd=%0d coal=%0d required 0/0", fwd_count, coalesce_count);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_write_drain();
        wr_cycles = 0;
        wq_addr.delete();
        wq_data.delete();
        do_req(1'b0, 16'h1230, DATA_A);
        vectors++;
        if (lat !== 1 || wr_cycles !== 0 || count !== 2'd1) begin
            miscompares++;
            $display("FAIL write_accept lat=%0d pmem_wr_cycles=%0d count=%0d required 1/0/1",
                     lat, wr_cycles, count);
        end
        wait_empty();
        vectors++;
        if (wq_addr.size() !== 1 || wq_addr[0] !== 16'h1230 || wq_data[0] !== DATA_A) begin
            miscompares++;
            $display("FAIL write_drain entries=%0d addr=%h data=%h required 1/1230/%h",
                     wq_addr.size(), wq_addr.size() > 0 ? wq_addr[0] : 16'h0,
                     wq_data.size() > 0 ? wq_data[0] : '0, DATA_A);
        end
    endtask

    task automatic test_read_hit();
        wq_addr.delete();
        wq_data.delete();
        do_req(1'b0, 16'h1230, DATA_A);
        rd_cycles = 0;
        do_req(1'b1, 16'h1238, '0);
        vectors++;
        if (got_rdata !== DATA_A || rd_cycles !== 0 || lat !== 2) begin
            miscompares++;
            $display("FAIL read_hit rdata=%h pmem_rd_cycles=%0d lat=%0d required %h/0/2",
                     got_rdata, rd_cycles, lat, DATA_A);
        end
`ifdef EVICT_BUF_STATS_EN
        vectors++;
        if (fwd_count !== 16'd1) begin
            miscompares++;
            $display("FAIL fwd_count got=%0d required 1", fwd_count);
        end
`endif
        wait_empty();
        vectors++;
        if (rd_cycles !== 0) begin
            miscompares++;
            $display("FAIL read_hit_no_pmem pmem_rd_cycles=%0d required 0", rd_cycles);
        end
    endtask

    task automatic test_coalesce();
        wq_addr.delete();
        wq_data.delete();
        do_req(1'b0, 16'h2000, DATA_B);
        do_req(1'b0, 16'h2004, DATA_C);
        vectors++;
        if (count !== 2'd1 || lat !== 2) begin
            miscompares++;
            $display("FAIL coalesce_count count=%0d lat=%0d required 1/2", count, lat);
        end
`ifdef EVICT_BUF_STATS_EN
        vectors++;
        if (coalesce_count !== 16'd1) begin
            miscompares++;
            $display("FAIL coalesce_stat got=%0d required 1", coalesce_count);
        end
`endif
        wait_empty();
        vectors++;
        if (wq_addr.size() !== 1 || wq_addr[0] !== 16'h2000 || wq_data[0] !== DATA_C) begin
            miscompares++;
            $display("FAIL coalesce_drain entries=%0d addr=%h data=%h required 1/2000/%h",
                     wq_addr.size(), wq_addr.size() > 0 ? wq_addr[0] : 16'h0,
                     wq_data.size() > 0 ? wq_data[0] : '0, DATA_C);
        end
    endtask

    task automatic test_back_to_back();
        wq_addr.delete();
        wq_data.delete();
        do_req(1'b0, 16'h1000, DATA_D1);
        do_req(1'b0, 16'h2000, DATA_D2);
        vectors++;
        if (count !== 2'd2) begin
            miscompares++;
            $display("FAIL full_count got=%0d required 2", count);
        end
        do_req(1'b0, 16'h3000, DATA_D3);
        vectors++;
        if (lat <= 2 || wq_addr.size() !== 1 || count !== 2'd2) begin
            miscompares++;
            $display("FAIL full_stall lat=%0d drained=%0d count=%0d required >2/1/2",
                     lat, wq_addr.size(), count);
        end
        wait_empty();
        vectors++;
        if (wq_addr.size() !== 3 ||
            wq_addr[0] !== 16'h1000 || wq_addr[1] !== 16'h2000 || wq_addr[2] !== 16'h3000 ||
            wq_data[0] !== DATA_D1 || wq_data[1] !== DATA_D2 || wq_data[2] !== DATA_D3) begin
            miscompares++;
            $display("FAIL drain_order entries=%0d required 3 in order 1000,2000,3000 with D1,D2,D3",
                     wq_addr.size());
        end
    endtask

    task automatic test_read_miss();
        rq_addr.delete();
        do_req(1'b0, 16'h1000, DATA_E);
        do_req(1'b1, 16'h4000, '0);
        vectors++;
        if (rq_addr.size() !== 1 || rq_addr[0] !== 16'h4000) begin
            miscompares++;
            $display("FAIL miss_addr reads=%0d addr=%h required 1/4000",
                     rq_addr.size(), rq_addr.size() > 0 ? rq_addr[0] : 16'h0);
        end
        vectors++;
        if (got_rdata !== RD_4000 || resp_cyc !== rd_resp_cyc + 1 || count !== 2'd1) begin
            miscompares++;
            $display("FAIL miss_resp rdata=%h resp_cyc=%0d pmem_resp_cyc=%0d count=%0d required %h/+1/1",
                     got_rdata, resp_cyc, rd_resp_cyc, count, RD_4000);
        end
        wait_empty();
    endtask

    task automatic test_reset_in_drain();
        int seen;
        mem_en = 1'b0;
        do_req(1'b0, 16'h5000, DATA_A);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_start pmem_write never asserted, required 1");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (pmem_write !== 1'b0 || count !== 2'd0 || cache_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drain pmem_write=%b count=%0d resp=%b required 0/0/0",
                     pmem_write, count, cache_resp);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (cache_resp || pmem_write || pmem_read) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_quiet active_cycles=%0d required 0", seen);
        end
`ifdef EVICT_BUF_STATS_EN
        vectors++;
        if (fwd_count !== 16'd0 || coalesce_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_stats_clear fwd=%0d coal=%0d required 0/0", fwd_count, coalesce_count);
        end
`endif
        mem_en = 1'b1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        wr_cycles     = 0;
        rd_cycles     = 0;
        both_cycles   = 0;
        rd_resp_cyc   = 0;
        mem_en        = 1'b1;
        reset         = 1'b1;
        cache_read    = 1'b0;
        cache_write   = 1'b0;
        cache_address = '0;
        cache_wdata   = '0;
`ifdef EVICT_BUF_STATS_EN
        stats_reset   = 1'b0;
`endif
        test_reset();
        test_write_drain();
        test_read_hit();
        test_coalesce();
        test_back_to_back();
        test_read_miss();
        test_reset_in_drain();
        vectors++;
        if (both_cycles !== 0) begin
            miscompares++;
            $display("FAIL strobe_exclusive both_cycles=%0d required 0", both_cycles);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
